uart_rx: RTL and testbench

Serial UART receiver for the FPGA samples: recovers 8-bit characters, LSB first, 8N1 framing, from an asynchronous serial line. It is the receive-side counterpart of the existing `uart_tx`. Baud timing uses the same divisor constants from `baudgen.vh` (`B9600` etc.), so a TX/RX pair configured with the same constant interoperates. It sits between the board's RS-232 RX pin and user logic, for example an echo or character-display design.

---
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined); mid-bit sampling
// driven by a BAUDRATE-cycle counter restarted at every sample point.
module uart_rx #(
  parameter int BAUDRATE = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       busy,
  output logic       ferr,
  output logic       perr
);

  localparam int CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] C_HALF = CW'(BAUDRATE / 2);
  localparam logic [CW-1:0] C_FULL = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAITHI
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic f_even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [1:0]    r_sync;
  logic          w_rxs;
  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [7:0]    r_data, w_data_next;
  logic          r_rcv, w_rcv_next;
  logic          r_ferr, w_ferr_next;
  logic          r_perr, w_perr_next;
  logic          r_busy;
`ifdef UART_RX_PARITY_EN
  logic          r_par_bad, w_par_bad_next;
`endif

  assign w_rxs = r_sync[1];
  assign data  = r_data;
  assign rcv   = r_rcv;
  assign busy  = r_busy;
  assign ferr  = r_ferr;
  assign perr  = r_perr;

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // Next-state, datapath and output-pulse decode
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + C_ONE;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_rcv_next   = 1'b0;
    w_ferr_next  = 1'b0;
    w_perr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_next = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        w_bit_next = 3'd0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = 1'b0;
`endif
        if (!w_rxs) begin
          w_state_next = S_START;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_next   = '0;
          w_state_next = w_rxs ? S_IDLE : S_DATA;
        end else begin
          w_state_next = S_START;
        end
      end
      S_DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rxs, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_state_next = S_DATA;
          end
        end else begin
          w_state_next = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == C_FULL) begin
          w_cnt_next     = '0;
          w_par_bad_next = (w_rxs != f_even_parity(r_shift));
          w_state_next   = S_STOP;
        end else begin
          w_state_next = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_next = '0;
          if (w_rxs) begin
            w_data_next  = r_shift;
            w_rcv_next   = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_next  = r_par_bad;
`endif
            w_state_next = S_IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = S_WAITHI;
          end
        end else begin
          w_state_next = S_STOP;
        end
      end
      // A held-low line parks here so a break yields a single framing error
      S_WAITHI: begin
        w_cnt_next = '0;
        if (w_rxs) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAITHI;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_rcv   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_rcv   <= w_rcv_next;
      r_ferr  <= w_ferr_next;
      r_perr  <= w_perr_next;
      r_busy  <= (w_state_next != S_IDLE);
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at BAUDRATE = 16 with a data scoreboard.
module tb_uart_rx;

  localparam int BR = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [7:0] data;
  logic       rcv, busy, ferr, perr;

  int n_checks = 0;
  int n_errors = 0;
  int n_rcv = 0, n_ferr = 0, n_perr = 0;
  int busy_run = 0, last_busy = 0;
  int cyc = 0, rcv_t_prev = 0, rcv_t_last = 0;
  logic prev_rcv = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(.BAUDRATE(BR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .busy (busy),
    .ferr (ferr),
    .perr (perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on rcv, pulse counters, busy run length
  always @(negedge clk) begin
    if (rcv === 1'b1) begin
      n_rcv++;
      rcv_t_prev = rcv_t_last;
      rcv_t_last = cyc;
      chk("rcv_one_cycle", {31'd0, prev_rcv}, 32'd0);
      chk("rcv_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) chk("rcv_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
    end
    prev_rcv = (rcv === 1'b1);
    if (ferr === 1'b1) n_ferr++;
    if (perr === 1'b1) n_perr++;
    if (busy === 1'b1) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (BR - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_rcv",  {31'd0, rcv},  32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_perr", {31'd0, perr}, 32'd0);
    rstn = 1'b1;
    idle(5);

    // Single character 'A'
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 1'b0);
    idle(10);
    chk("single_rcv_count", n_rcv, 32'd1);
    chk("single_data", {24'd0, data}, 32'h41);
    chk("single_busy_len", last_busy, BR / 2 + 9 * BR + 1);
    chk("single_ferr", n_ferr, 32'd0);

    // Glitch of 3 cycles
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    idle(20);
    chk("glitch_busy_len", last_busy, BR / 2 + 1);
    chk("glitch_rcv_count", n_rcv, 32'd1);
    chk("glitch_ferr", n_ferr, 32'd0);
    chk("glitch_data", {24'd0, data}, 32'h41);

    // Framing error followed by a held-low line
    send_frame(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("ferr_count", n_ferr, 32'd1);
    chk("ferr_data_held", {24'd0, data}, 32'h41);
    chk("ferr_no_rcv", n_rcv, 32'd1);
    idle(32);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b0);
    idle(10);
    chk("after_ferr_rcv", n_rcv, 32'd2);
    chk("after_ferr_data", {24'd0, data}, 32'h00);
    chk("after_ferr_count", n_ferr, 32'd1);

    // Back-to-back frames
    exp_q.push_back(8'h41);
    exp_q.push_back(8'hC3);
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(10);
    chk("b2b_rcv_count", n_rcv, 32'd4);
    chk("b2b_spacing", rcv_t_last - rcv_t_prev, 10 * BR);
    chk("b2b_data", {24'd0, data}, 32'hC3);

    // Reset during bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_data", {24'd0, data}, 32'h00);
    chk("rst_mid_rcv",  {31'd0, rcv},  32'd0);
    chk("rst_mid_ferr", {31'd0, ferr}, 32'd0);
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    idle(40);
    chk("rst_mid_no_rcv", n_rcv, 32'd4);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(10);
    chk("after_rst_rcv", n_rcv, 32'd5);
    chk("after_rst_data", {24'd0, data}, 32'h5A);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 1'b1);
    idle(10);
    chk("par_bad_perr", n_perr, 32'd1);
    chk("par_bad_rcv", n_rcv, 32'd6);
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 1'b0);
    idle(10);
    chk("par_ok_perr", n_perr, 32'd1);
    chk("par_ok_rcv", n_rcv, 32'd7);
    chk("par_ok_data", {24'd0, data}, 32'h41);
`else
    chk("perr_never", n_perr, 32'd0);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("final_ferr_total", n_ferr, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
